// File: rtl/sync_updown_cntr_if.sv
// Purpose : control and status bundle for sync_updown_cntr.
// Ports   : master drives en/up_down/step/sat_mode/clr/load/load_val and
//           observes count/ovf/unf/at_max/at_min/tc; slave is the counter.
interface sync_updown_cntr_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STEP_W = 4
);
   logic              en;
   logic              up_down;
   logic [STEP_W-1:0] step;
   logic              sat_mode;
   logic              clr;
   logic              load;
   logic [WIDTH-1:0]  load_val;
   logic [WIDTH-1:0]  count;
   logic              ovf;
   logic              unf;
   logic              at_max;
   logic              at_min;
   logic              tc;

   modport master (
      output en, up_down, step, sat_mode, clr, load, load_val,
      input  count, ovf, unf, at_max, at_min, tc
   );

   modport slave (
      input  en, up_down, step, sat_mode, clr, load, load_val,
      output count, ovf, unf, at_max, at_min, tc
   );
endinterface

// File: rtl/sync_updown_cntr.sv
// Purpose : parametrised up/down counter over 0..MAX_VAL with clamped step,
//           sync clear/load, wrap or saturate mode, registered ovf/unf pulses
//           and combinational at_max/at_min/tc for cascading.
// Ports   : clk, rst (async, active-high); bus (slave modport) carries the
//           controls (en, up_down, step, sat_mode, clr, load, load_val) and
//           status (count, ovf, unf, at_max, at_min, tc).
module sync_updown_cntr #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MAX_VAL = 2**WIDTH - 1,
   parameter int unsigned STEP_W  = 4
) (
   input  logic                clk,
   input  logic                rst,
   sync_updown_cntr_if.slave   bus
);

   localparam int unsigned CW = WIDTH + 1;
   // Common width wide enough to compare step against MAX_VAL without loss.
   localparam int unsigned XW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
   localparam logic [CW-1:0]    MAX_C = CW'(MAX_VAL);
   localparam logic [CW-1:0]    MOD_C = CW'(MAX_VAL + 1);
   localparam logic [XW-1:0]    MAX_X = XW'(MAX_VAL);

   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [XW-1:0]    step_x;
   logic [WIDTH-1:0] step_s;
   logic [WIDTH-1:0] ld_s;
   logic [CW-1:0]    sum_up;
   logic [CW-1:0]    wrap_dn;

   // Next-count and crossing-flag computation, priority clr > load > en.
   always_comb begin
      step_x  = XW'(bus.step);
      step_s  = (step_x > MAX_X) ? MAX_W : WIDTH'(step_x);
      ld_s    = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
      sum_up  = CW'(count_q) + CW'(step_s);
      // Add the modulus before subtracting so the borrow case stays positive.
      wrap_dn = CW'(count_q) + MOD_C - CW'(step_s);

      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;

      if (bus.clr) begin
         count_d = '0;
      end else if (bus.load) begin
         count_d = ld_s;
      end else if (bus.en) begin
         if (bus.up_down) begin
            if (sum_up > MAX_C) begin
               ovf_d   = 1'b1;
               count_d = bus.sat_mode ? MAX_W : WIDTH'(sum_up - MOD_C);
            end else begin
               count_d = WIDTH'(sum_up);
            end
         end else begin
            if (count_q >= step_s) begin
               count_d = count_q - step_s;
            end else begin
               unf_d   = 1'b1;
               count_d = bus.sat_mode ? '0 : WIDTH'(wrap_dn);
            end
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign bus.count  = count_q;
   assign bus.ovf    = ovf_q;
   assign bus.unf    = unf_q;
   assign bus.at_max = (count_q == MAX_W);
   assign bus.at_min = (count_q == '0);
   assign bus.tc     = bus.en & ((bus.up_down & bus.at_max) |
                                 (~bus.up_down & bus.at_min));

endmodule

// File: tb/tb_sync_updown_cntr.sv
module tb_sync_updown_cntr;

   localparam int unsigned W  = 4;
   localparam int unsigned MV = 9;
   localparam int unsigned SW = 4;

   typedef struct {
      logic [W-1:0] cnt;
      logic         ovf;
      logic         unf;
      logic         tc;
      string        tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;
   exp_t sb_q[$];
   event chk_now;

   sync_updown_cntr_if #(.WIDTH(W), .STEP_W(SW)) bus ();

   sync_updown_cntr #(.WIDTH(W), .MAX_VAL(MV), .STEP_W(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic cmp1(input string tag, input string fld, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s.%s: got %0d, expected %0d", tag, fld, act, req);
      end
   endtask

   task automatic compare(input exp_t e);
      cmp1(e.tag, "count",  int'(bus.count),  int'(e.cnt));
      cmp1(e.tag, "ovf",    int'(bus.ovf),    int'(e.ovf));
      cmp1(e.tag, "unf",    int'(bus.unf),    int'(e.unf));
      cmp1(e.tag, "at_max", int'(bus.at_max), (e.cnt == W'(MV)) ? 1 : 0);
      cmp1(e.tag, "at_min", int'(bus.at_min), (e.cnt == '0) ? 1 : 0);
      cmp1(e.tag, "tc",     int'(bus.tc),     int'(e.tc));
   endtask

   // Monitor: after every edge the DUT presents a fresh count; pop and compare.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) compare(sb_q.pop_front());
      end
   end

   // Monitor for between-edge (asynchronous reset) observations.
   initial begin
      forever begin
         @(chk_now);
         if (sb_q.size() != 0) compare(sb_q.pop_front());
      end
   end

   task automatic push(input string tag, input logic [W-1:0] ec,
                       input logic eo, input logic eu);
      exp_t e;
      e.cnt = ec;
      e.ovf = eo;
      e.unf = eu;
      e.tc  = bus.en & (bus.up_down ? (ec == W'(MV)) : (ec == '0));
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   // Drive one cycle's inputs at the falling edge and queue the hand-computed
   // result expected after the following rising edge.
   task automatic cyc(input string tag, input logic e, input logic ud,
                      input logic [SW-1:0] st, input logic sm, input logic cl,
                      input logic ld, input logic [W-1:0] lv,
                      input logic [W-1:0] ec, input logic eo, input logic eu);
      @(negedge clk);
      bus.en       = e;
      bus.up_down  = ud;
      bus.step     = st;
      bus.sat_mode = sm;
      bus.clr      = cl;
      bus.load     = ld;
      bus.load_val = lv;
      push(tag, ec, eo, eu);
   endtask

   task automatic idle();
      bus.en = 1'b0; bus.up_down = 1'b0; bus.step = '0; bus.sat_mode = 1'b0;
      bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      #2;
      push("reset_init", 4'd0, 1'b0, 1'b0);
      -> chk_now;
      @(negedge clk);
      rst = 1'b0;

      // Up wrap, step 1
      cyc("clr0", 0,1,4'd0,0, 1,0,4'd0, 4'd0,0,0);
      for (int i = 1; i <= 9; i++)
         cyc($sformatf("up%0d", i), 1,1,4'd1,0, 0,0,4'd0, W'(i),0,0);
      cyc("up_wrap", 1,1,4'd1,0, 0,0,4'd0, 4'd0,1,0);

      // Down wrap, step 3
      cyc("ld1",   0,0,4'd0,0, 0,1,4'd1, 4'd1,0,0);
      cyc("dn_w1", 1,0,4'd3,0, 0,0,4'd0, 4'd8,0,1);
      cyc("dn_5",  1,0,4'd3,0, 0,0,4'd0, 4'd5,0,0);
      cyc("dn_2",  1,0,4'd3,0, 0,0,4'd0, 4'd2,0,0);
      cyc("dn_w2", 1,0,4'd3,0, 0,0,4'd0, 4'd9,0,1);

      // Saturate, step 4
      cyc("ld7",    0,1,4'd0,1, 0,1,4'd7, 4'd7,0,0);
      cyc("sat_u1", 1,1,4'd4,1, 0,0,4'd0, 4'd9,1,0);
      cyc("sat_u2", 1,1,4'd4,1, 0,0,4'd0, 4'd9,1,0);
      cyc("sat_d5", 1,0,4'd4,1, 0,0,4'd0, 4'd5,0,0);
      cyc("sat_d1", 1,0,4'd4,1, 0,0,4'd0, 4'd1,0,0);
      cyc("sat_d0", 1,0,4'd4,1, 0,0,4'd0, 4'd0,0,1);
      cyc("sat_d0b",1,0,4'd4,1, 0,0,4'd0, 4'd0,0,1);

      // Reset mid-operation with a pending ovf: 9+7 wraps to 6
      cyc("ld9",   0,1,4'd0,0, 0,1,4'd9, 4'd9,0,0);
      cyc("up7",   1,1,4'd7,0, 0,0,4'd0, 4'd6,1,0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      push("reset_mid", 4'd0, 1'b0, 1'b0);
      -> chk_now;
      @(negedge clk);
      idle();
      @(negedge clk);
      rst = 1'b0;
      cyc("resume", 1,1,4'd1,0, 0,0,4'd0, 4'd1,0,0);

      // Priority and clamping
      cyc("ld_clamp", 0,0,4'd0,0, 0,1,4'd12, 4'd9,0,0);
      cyc("ld_vs_en", 1,1,4'd1,0, 0,1,4'd3,  4'd3,0,0);
      cyc("clr_vs_ld",0,0,4'd0,0, 1,1,4'd5,  4'd0,0,0);

      // Hold cases and step clamp
      cyc("ld5",     0,0,4'd0,0, 0,1,4'd5,  4'd5,0,0);
      cyc("hold_u",  0,1,4'd3,0, 0,0,4'd0,  4'd5,0,0);
      cyc("hold_d",  0,0,4'd3,0, 0,0,4'd0,  4'd5,0,0);
      cyc("step0",   1,1,4'd0,0, 0,0,4'd0,  4'd5,0,0);
      cyc("step15",  1,1,4'd15,0,0,0,4'd0,  4'd4,1,0);
      cyc("flag_off",0,1,4'd0,0, 0,0,4'd0,  4'd4,0,0);

      @(negedge clk);
      idle();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
